mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter that shares the single-port 1024x16 synchronous program/data RAM between the CPU (port A) and a second bus master (port B, e.g. a display fetcher or program loader).
- Grants at most one access per cycle, muxes the address, write-enable and write data onto the RAM, and routes registered read data back to its requester with a one-cycle valid strobe.
- Uses round-robin arbitration with a bounded lock, so a bursting master cannot starve the other.

Parameters:
- AW, 10, RAM address width.
- DW, 16, RAM data width.
- MAX_BURST, 8, maximum consecutive grants to a locked requester while the other is requesting (1..255).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- a_req  in  1  port A access request, held until a_gnt.
- a_we  in  1  port A write (1) / read (0).
- a_lock  in  1  port A asks to keep ownership on following cycles.
- a_addr  in  AW  port A address.
- a_wdata  in  DW  port A write data.
- a_gnt  out  1  port A request accepted this cycle.
- a_rvalid  out  1  port A read data valid.
- a_rdata  out  DW  port A read data.
- b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as port A, for port B.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM registered read data (valid the cycle after the address).

Behaviour:
- Reset (reset=0, asynchronous): gnt, rvalid and ram_we = 0; ram_addr and ram_wdata = 0; last_winner = B (so A wins the first tie); owner = none; burst_cnt = 0.
- Grant is combinational in the request cycle N:
  - Winner's addr, we and wdata drive the RAM.
  - Winner's gnt = 1; loser's gnt = 0.
- Selection order:
  - If owner is set, its req is high, and (burst_cnt < MAX_BURST or the other req is low): the owner wins.
  - Else if only one req is high: it wins.
  - Else if both are high: the requester that is not last_winner wins.
  - Else: no grant, and ram_we = 0.
- Lock:
  - On a grant with that requester's lock = 1: owner = winner.
  - burst_cnt increments on consecutive owner grants that occur while the other is requesting, and saturates at MAX_BURST.
  - Owner clears, and burst_cnt returns to 0, when the owner grants without lock, drops req, or is preempted at MAX_BURST.
  - A preempted owner loses ownership. It re-arbitrates normally.
- Read return:
  - Registered flag rd_src is recorded for a granted read.
  - In N+1, x_rvalid = 1 for one cycle, and x_rdata = ram_rdata.
  - Writes produce no rvalid.
  - Back-to-back reads (any mix of A and B) sustain one read per cycle.
- x_rdata holds its last value when rvalid = 0.
- Writes complete at the end of the grant cycle. A read of the same address in N+1 returns the new data.
- Reset mid-operation: a pending rvalid is dropped and ownership is cleared. No RAM write occurs while reset = 0.
- Requests with req = 0 are ignored regardless of we, lock or addr.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- Defined:
  - Adds outputs a_stall_cnt[15:0] and b_stall_cnt[15:0].
  - Each counts cycles where that req = 1 and gnt = 0.
  - Counters saturate at 16'hFFFF and reset to 0.
  - Adds input stats_clr, a synchronous clear that wins over increment.
- Undefined: these ports and counters are absent. Arbitration is unchanged.

Test Plan:
- Single master: a_req=1, a_we=1, a_addr=10'h005, a_wdata=16'd233; next cycle a read of 10'h005 -> a_gnt each cycle; a_rvalid=1 one cycle after the read grant; a_rdata=233; b_* outputs stay 0.
- Tie after reset: a_req=b_req=1, reads of 10'h010 and 10'h020 (preloaded 100 and 60) -> A granted in cycle 0 and B in cycle 1; a_rdata=100, b_rdata=60 with rvalids in cycles 1 and 2.
- Continuous contention: both reads for 6 cycles -> grants alternate A,B,A,B,A,B; no cycle has both gnts or an idle RAM.
- Lock bound: MAX_BURST=4, b_lock=1 and b_req=1 held, a_req rises while B owns -> B gets 4 more grants, then A is granted; B's ownership is cleared.
- Reset mid-read: assert reset=0 in the cycle after an A read grant -> a_rvalid stays 0, ram_we=0; after release, the first tie goes to A.
- With MEM_ARB_STATS_EN: contention test above -> a_stall_cnt=3, b_stall_cnt=3; pulse stats_clr -> both read 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port synchronous RAM (registered read data, one-cycle
//   latency) between two bus masters, A (CPU) and B (secondary master).
//   At most one access is granted per cycle. Ties alternate between the
//   masters (round-robin). A master that asks for lock keeps ownership on
//   following cycles, up to MAX_BURST grants while the other master waits.
//
// Parameters
//   AW        RAM address width
//   DW        RAM data width
//   MAX_BURST consecutive owner grants allowed while the other master waits
//
// Ports
//   clk                  system clock, rising edge
//   reset                asynchronous, active-low reset
//   x_req/x_we/x_lock    request, write(1)/read(0), keep-ownership  (x = a, b)
//   x_addr/x_wdata       request address and write data
//   x_gnt                request accepted this cycle (combinational)
//   x_rvalid/x_rdata     read data return, one cycle after the read grant;
//                        x_rdata holds its last value while x_rvalid = 0
//   ram_we/ram_addr/ram_wdata  RAM command of the granted master
//   ram_rdata            registered RAM read data
//
// Optional build macro MEM_ARB_STATS_EN adds per-master stall counters
//   stats_clr            synchronous clear of both counters (beats increment)
//   a_stall_cnt/b_stall_cnt  saturating counts of cycles with req=1, gnt=0
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int AW        = 10,
   parameter int DW        = 16,
   parameter int MAX_BURST = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          a_req,
   input  logic          a_we,
   input  logic          a_lock,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_gnt,
   output logic          a_rvalid,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic          b_lock,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_gnt,
   output logic          b_rvalid,
   output logic [DW-1:0] b_rdata,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
`ifdef MEM_ARB_STATS_EN
   ,
   input  logic          stats_clr,
   output logic [15:0]   a_stall_cnt,
   output logic [15:0]   b_stall_cnt
`endif
);

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_A    = 2'd1;
   localparam logic [1:0] OWN_B    = 2'd2;
   localparam logic [7:0] MAX_B    = 8'(MAX_BURST);

   logic [1:0]    owner_q, owner_d;
   logic [7:0]    burst_q, burst_d;
   logic          last_b_q, last_b_d;   // 1: B won the most recent grant
   logic          rd_vld_q, rd_vld_d;
   logic          rd_b_q, rd_b_d;       // source of the read in flight
   logic [DW-1:0] a_hold_q, a_hold_d;
   logic [DW-1:0] b_hold_q, b_hold_d;

   logic gnt_a, gnt_b;
   logic owner_req, other_req, owner_wins, win_lock;

   // The owner keeps the RAM unless it has used up its burst while the
   // other master is waiting.
   assign owner_req  = (owner_q == OWN_B) ? b_req : a_req;
   assign other_req  = (owner_q == OWN_B) ? a_req : b_req;
   assign owner_wins = (owner_q != OWN_NONE) && owner_req &&
                       ((burst_q < MAX_B) || !other_req);

   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (!reset) begin
         // no grants (and therefore no RAM writes) while held in reset
      end else if (owner_wins) begin
         gnt_a = (owner_q == OWN_A);
         gnt_b = (owner_q == OWN_B);
      end else if (a_req && !b_req) begin
         gnt_a = 1'b1;
      end else if (b_req && !a_req) begin
         gnt_b = 1'b1;
      end else if (a_req && b_req) begin
         gnt_a = last_b_q;
         gnt_b = !last_b_q;
      end
   end

   assign a_gnt     = gnt_a;
   assign b_gnt     = gnt_b;
   assign ram_we    = (gnt_a && a_we) || (gnt_b && b_we);
   assign ram_addr  = gnt_a ? a_addr  : (gnt_b ? b_addr  : '0);
   assign ram_wdata = gnt_a ? a_wdata : (gnt_b ? b_wdata : '0);
   assign win_lock  = gnt_a ? a_lock  : (gnt_b && b_lock);

   always_comb begin
      owner_d  = owner_q;
      burst_d  = burst_q;
      last_b_d = last_b_q;
      // Owner that dropped its request or was preempted loses ownership.
      if (!owner_wins) begin
         owner_d = OWN_NONE;
         burst_d = '0;
      end
      if (gnt_a || gnt_b) begin
         last_b_d = gnt_b;
         if (win_lock) begin
            if (owner_wins) begin
               if (other_req && (burst_q < MAX_B)) burst_d = burst_q + 8'd1;
            end else begin
               owner_d = gnt_b ? OWN_B : OWN_A;
               burst_d = '0;
            end
         end else begin
            owner_d = OWN_NONE;
            burst_d = '0;
         end
      end
   end

   assign rd_vld_d = (gnt_a && !a_we) || (gnt_b && !b_we);
   assign rd_b_d   = gnt_b;

   assign a_rvalid = rd_vld_q && !rd_b_q;
   assign b_rvalid = rd_vld_q && rd_b_q;
   assign a_rdata  = a_rvalid ? ram_rdata : a_hold_q;
   assign b_rdata  = b_rvalid ? ram_rdata : b_hold_q;
   assign a_hold_d = a_rdata;
   assign b_hold_d = b_rdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner_q  <= OWN_NONE;
         burst_q  <= '0;
         last_b_q <= 1'b1;
         rd_vld_q <= 1'b0;
         rd_b_q   <= 1'b0;
         a_hold_q <= '0;
         b_hold_q <= '0;
      end else begin
         owner_q  <= owner_d;
         burst_q  <= burst_d;
         last_b_q <= last_b_d;
         rd_vld_q <= rd_vld_d;
         rd_b_q   <= rd_b_d;
         a_hold_q <= a_hold_d;
         b_hold_q <= b_hold_d;
      end
   end

`ifdef MEM_ARB_STATS_EN
   logic [15:0] a_stall_q, a_stall_d;
   logic [15:0] b_stall_q, b_stall_d;

   always_comb begin
      a_stall_d = a_stall_q;
      b_stall_d = b_stall_q;
      if (stats_clr) begin
         a_stall_d = '0;
         b_stall_d = '0;
      end else begin
         if (a_req && !gnt_a && (a_stall_q != 16'hFFFF)) a_stall_d = a_stall_q + 16'd1;
         if (b_req && !gnt_b && (b_stall_q != 16'hFFFF)) b_stall_d = b_stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_stall_q <= '0;
         b_stall_q <= '0;
      end else begin
         a_stall_q <= a_stall_d;
         b_stall_q <= b_stall_d;
      end
   end

   assign a_stall_cnt = a_stall_q;
   assign b_stall_cnt = b_stall_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
   localparam int AW   = 10;
   localparam int DW   = 16;
   localparam int MAXB = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          a_req, a_we, a_lock, b_req, b_we, b_lock;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_wdata, b_wdata;
   logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [DW-1:0] a_rdata, b_rdata;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;
   logic          stats_clr;
`ifdef MEM_ARB_STATS_EN
   logic [15:0]   a_stall_cnt, b_stall_cnt;
`endif

   mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef MEM_ARB_STATS_EN
      , .stats_clr(stats_clr), .a_stall_cnt(a_stall_cnt), .b_stall_cnt(b_stall_cnt)
`endif
   );

   // Synchronous single-port RAM with registered read data.
   logic [DW-1:0] ram_mem [0:1023];
   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
   end

   int checks   = 0;
   int failures = 0;

   // Reference model: owner (-1 none, 0 A, 1 B), streak length, last winner,
   // memory image, read in flight and the per-port held read data.
   int          m_owner, m_streak, m_last, m_rd;
   logic [15:0] m_rdval;
   logic [15:0] m_hold [2];
   logic [15:0] m_mem  [0:1023];
   int          m_stall [2];

   // Values observed in the most recent cycle.
   logic        s_ag, s_bg, s_av, s_bv;
   logic [15:0] s_ad, s_bd;
   int          s_w;
`ifdef MEM_ARB_STATS_EN
   logic [15:0] s_ast, s_bst;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_streak = 0; m_last = 1; m_rd = -1; m_rdval = '0;
      m_hold[0] = '0; m_hold[1] = '0;
      m_stall[0] = 0; m_stall[1] = 0;
   endtask

   task automatic zero_inputs();
      a_req = 0; a_we = 0; a_lock = 0; a_addr = '0; a_wdata = '0;
      b_req = 0; b_we = 0; b_lock = 0; b_addr = '0; b_wdata = '0;
      stats_clr = 0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_a_gnt"},    32'(a_gnt),     32'd0);
      chk({tag, "_b_gnt"},    32'(b_gnt),     32'd0);
      chk({tag, "_ram_we"},   32'(ram_we),    32'd0);
      chk({tag, "_ram_addr"}, 32'(ram_addr),  32'd0);
      chk({tag, "_ram_wdata"},32'(ram_wdata), 32'd0);
      chk({tag, "_a_rvalid"}, 32'(a_rvalid),  32'd0);
      chk({tag, "_b_rvalid"}, 32'(b_rvalid),  32'd0);
`ifdef MEM_ARB_STATS_EN
      chk({tag, "_a_stall"},  32'(a_stall_cnt), 32'd0);
      chk({tag, "_b_stall"},  32'(b_stall_cnt), 32'd0);
`endif
   endtask

   // Hold reset for a few cycles (inputs may be active), then release.
   task automatic apply_reset(input string tag);
      reset = 1'b0;
      model_reset();
      #1;
      chk_reset_outputs(tag);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk_reset_outputs({tag, "_held"});
      zero_inputs();
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // One clock cycle: called just after a rising edge with inputs set.
   task automatic cycle();
      int w, lk, oth;
      bit rq0, rq1;
      logic [15:0] ea, eb;
      @(negedge clk);
      #1;
      rq0 = a_req; rq1 = b_req;
      w = -1;
      if (m_owner == 0 && rq0 && (m_streak < MAXB || !rq1))      w = 0;
      else if (m_owner == 1 && rq1 && (m_streak < MAXB || !rq0)) w = 1;
      else if (rq0 && !rq1) w = 0;
      else if (rq1 && !rq0) w = 1;
      else if (rq0 && rq1)  w = 1 - m_last;

      chk("a_gnt",  32'(a_gnt),  32'(w == 0));
      chk("b_gnt",  32'(b_gnt),  32'(w == 1));
      chk("ram_we", 32'(ram_we), 32'((w == 0) ? a_we : ((w == 1) ? b_we : 1'b0)));
      if (w == 0) begin
         chk("ram_addr_a",  32'(ram_addr),  32'(a_addr));
         chk("ram_wdata_a", 32'(ram_wdata), 32'(a_wdata));
      end else if (w == 1) begin
         chk("ram_addr_b",  32'(ram_addr),  32'(b_addr));
         chk("ram_wdata_b", 32'(ram_wdata), 32'(b_wdata));
      end
      ea = (m_rd == 0) ? m_rdval : m_hold[0];
      eb = (m_rd == 1) ? m_rdval : m_hold[1];
      chk("a_rvalid", 32'(a_rvalid), 32'(m_rd == 0));
      chk("b_rvalid", 32'(b_rvalid), 32'(m_rd == 1));
      chk("a_rdata",  32'(a_rdata),  32'(ea));
      chk("b_rdata",  32'(b_rdata),  32'(eb));
`ifdef MEM_ARB_STATS_EN
      chk("a_stall_cnt", 32'(a_stall_cnt), 32'(m_stall[0]));
      chk("b_stall_cnt", 32'(b_stall_cnt), 32'(m_stall[1]));
      s_ast = a_stall_cnt; s_bst = b_stall_cnt;
`endif
      s_ag = a_gnt; s_bg = b_gnt; s_av = a_rvalid; s_bv = b_rvalid;
      s_ad = a_rdata; s_bd = b_rdata; s_w = w;

      // Advance the model to the next rising edge.
      if (m_rd >= 0) m_hold[m_rd] = m_rdval;
      m_rd = -1;
      if (w == 0) begin
         if (a_we) m_mem[a_addr] = a_wdata;
         else begin m_rd = 0; m_rdval = m_mem[a_addr]; end
      end else if (w == 1) begin
         if (b_we) m_mem[b_addr] = b_wdata;
         else begin m_rd = 1; m_rdval = m_mem[b_addr]; end
      end
      lk  = (w == 0) ? int'(a_lock) : ((w == 1) ? int'(b_lock) : 0);
      oth = (w == 0) ? int'(rq1) : int'(rq0);
      if (w >= 0 && lk != 0) begin
         if (w == m_owner) begin
            if (oth != 0 && m_streak < MAXB) m_streak++;
         end else begin
            m_owner = w; m_streak = 0;
         end
      end else begin
         m_owner = -1; m_streak = 0;
      end
      if (w >= 0) m_last = w;
      if (stats_clr) begin
         m_stall[0] = 0; m_stall[1] = 0;
      end else begin
         if (rq0 && w != 0 && m_stall[0] < 65535) m_stall[0]++;
         if (rq1 && w != 1 && m_stall[1] < 65535) m_stall[1]++;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      zero_inputs();
      model_reset();
      reset = 1'b0;
      #2;
      // Active write request while in reset must not reach the RAM.
      a_req = 1; a_we = 1; a_lock = 1; a_addr = 10'h005; a_wdata = 16'h1234;
      apply_reset("rst0");

      // Single master: write then read back.
      a_req = 1; a_we = 1; a_addr = 10'h005; a_wdata = 16'd233;
      cycle();
      chk("sm_wr_gnt", 32'(s_ag), 32'd1);
      a_we = 0;
      cycle();
      chk("sm_rd_gnt", 32'(s_ag), 32'd1);
      a_req = 0;
      cycle();
      chk("sm_rvalid",  32'(s_av), 32'd1);
      chk("sm_rdata",   32'(s_ad), 32'd233);
      chk("sm_b_rvalid",32'(s_bv), 32'd0);
      chk("sm_b_rdata", 32'(s_bd), 32'd0);

      // Preload the address window used by later reads.
      a_req = 1; a_we = 1;
      for (int i = 0; i < 16; i++) begin
         a_addr = 10'(i); a_wdata = 16'($urandom);
         cycle();
      end
      a_addr = 10'h010; a_wdata = 16'd100; cycle();
      a_addr = 10'h020; a_wdata = 16'd60;  cycle();
      a_req = 0; a_we = 0;
      cycle();
      apply_reset("rst1");

      // Tie right after reset goes to A.
      a_req = 1; a_addr = 10'h010; b_req = 1; b_addr = 10'h020;
      cycle();
      chk("tie_c0_a", 32'(s_ag), 32'd1);
      chk("tie_c0_b", 32'(s_bg), 32'd0);
      a_req = 0;
      cycle();
      chk("tie_c1_b",      32'(s_bg), 32'd1);
      chk("tie_c1_rvalid", 32'(s_av), 32'd1);
      chk("tie_c1_rdata",  32'(s_ad), 32'd100);
      b_req = 0;
      cycle();
      chk("tie_c2_rvalid", 32'(s_bv), 32'd1);
      chk("tie_c2_rdata",  32'(s_bd), 32'd60);

      // Continuous contention alternates A,B,A,B,...
      stats_clr = 1; cycle(); stats_clr = 0;
      a_req = 1; a_addr = 10'h003; b_req = 1; b_addr = 10'h00C;
      for (int k = 0; k < 6; k++) begin
         cycle();
         chk("cont_onehot", 32'(s_ag ^ s_bg), 32'd1);
         chk("cont_order",  32'(s_ag), 32'(k % 2 == 0));
      end
      a_req = 0; b_req = 0;
      cycle();
`ifdef MEM_ARB_STATS_EN
      chk("stat_a_3", 32'(s_ast), 32'd3);
      chk("stat_b_3", 32'(s_bst), 32'd3);
      stats_clr = 1; cycle(); stats_clr = 0;
      cycle();
      chk("stat_a_clr", 32'(s_ast), 32'd0);
      chk("stat_b_clr", 32'(s_bst), 32'd0);
`endif

      // Lock bound: B owns, A arrives, B gets MAXB more grants then A.
      b_req = 1; b_lock = 1; b_addr = 10'h001;
      cycle();
      chk("lock_own_b", 32'(s_bg), 32'd1);
      a_req = 1; a_addr = 10'h002;
      for (int k = 0; k <= MAXB; k++) begin
         b_addr = 10'(k + 4);
         cycle();
         chk("lock_b_gnt", 32'(s_bg), 32'(k < MAXB));
         chk("lock_a_gnt", 32'(s_ag), 32'(k == MAXB));
      end
      a_addr = 10'h003;
      cycle();
      chk("lock_cleared_b", 32'(s_bg), 32'd1);
      zero_inputs();
      cycle();
      cycle();

      // Reset right after an A read grant drops the read return.
      a_req = 1; a_addr = 10'h004;
      cycle();
      chk("mid_a_gnt", 32'(s_ag), 32'd1);
      b_req = 1; b_we = 1; b_addr = 10'h007; b_wdata = 16'hDEAD;
      apply_reset("rst_mid");
      a_req = 1; a_addr = 10'h007; b_req = 1; b_addr = 10'h008;
      cycle();
      chk("post_rst_tie_a", 32'(s_ag), 32'd1);
      a_req = 0;
      cycle();
      chk("post_rst_no_write", 32'(s_ad), 32'(m_hold[0]));
      b_req = 0;
      cycle();

      // Randomized traffic; each master holds its request until granted.
      for (int n = 0; n < 400; n++) begin
         if (!a_req || s_w == 0) begin
            a_req   = ($urandom_range(0, 3) != 0);
            a_we    = 1'($urandom_range(0, 1));
            a_lock  = ($urandom_range(0, 2) == 0);
            a_addr  = 10'($urandom_range(0, 15));
            a_wdata = 16'($urandom);
         end
         if (!b_req || s_w == 1) begin
            b_req   = ($urandom_range(0, 3) != 0);
            b_we    = 1'($urandom_range(0, 1));
            b_lock  = ($urandom_range(0, 2) == 0);
            b_addr  = 10'($urandom_range(0, 15));
            b_wdata = 16'($urandom);
         end
         stats_clr = ($urandom_range(0, 31) == 0);
         cycle();
      end
      zero_inputs();
      cycle();
      cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
